tx_baudrate: RTL and testbench

UART transmitter with an internal baud-tick generator: the transmit-side counterpart of `rx_baudrate`. It accepts an `NB_DATA`-bit word through a valid/ready handshake and serialises it as `NB_DATA/8` consecutive 8N1 frames, least-significant byte first. It sits between the processor/top-level data source and the serial line. Its `o_tx` drives the `i_data` input of `rx_baudrate` in loopback.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/baud_tick_gen.sv | 37 +++
 rtl/tx_baudrate.sv | 166 ++++++++++++++++
 tb/tb_tx_baudrate.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (tx_baudrate) and the
// receiver (rx_baudrate): FSM state encoding, default frame/oversampling
// parameters and the baud-tick divisor calculation.
package uart_pkg;

  // Data bits per 8N1 frame.
  localparam int unsigned NB_BYTE_DEF = 8;
  // Baud ticks per bit (oversampling factor shared by TX and RX).
  localparam int unsigned N_TICKS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per baud tick, integer-truncated.
  function automatic int unsigned calc_div(input int unsigned f_clock,
                                           input int unsigned baud_rate,
                                           input int unsigned n_ticks);
    return f_clock / (baud_rate * n_ticks);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud tick generator shared by the UART transmitter and receiver.
// Counts 0..DIV-1 while enabled and flags the last count as a one-cycle
// tick; held at 0 while disabled so every enable starts a fresh period.
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous active-low reset
//   i_enable : run the counter
//   o_tick   : one-cycle pulse every DIV enabled clocks
module baud_tick_gen #(
  parameter int unsigned DIV = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (!i_enable || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // With DIV=1 the counter never leaves 0 and the tick follows the enable.
  always_comb begin
    o_tick = i_enable && (cnt == CNT_MAX);
  end

endmodule

// File: rtl/tx_baudrate.sv
// UART transmitter with internal baud-tick generator. Accepts an NB_DATA-bit
// word on a valid/ready handshake and sends it as NB_DATA/NB_BYTE back-to-back
// 8N1 frames, least-significant byte first.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   i_data  : word to send, sampled on acceptance
//   i_valid : word available
//   o_ready : can accept a word (high only in IDLE)
//   o_tx    : serial line, idle high
//   o_busy  : a word is being sent
//   o_done  : one-cycle pulse after the last stop bit of a word
module tx_baudrate
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA   = 16,
  parameter int unsigned NB_BYTE   = NB_BYTE_DEF,
  parameter int unsigned F_CLOCK   = 5000000,
  parameter int unsigned BAUD_RATE = 19200,
  parameter int unsigned N_TICKS   = N_TICKS_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned DIV      = calc_div(F_CLOCK, BAUD_RATE, N_TICKS);
  localparam int unsigned NB_WORDS = NB_DATA / NB_BYTE;
  localparam int unsigned BIT_W    = $clog2(NB_BYTE + 1);
  localparam int unsigned BYTE_W   = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int unsigned OS_W     = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_BYTE - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NB_WORDS - 1);
  localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(N_TICKS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tx_baudrate: F_CLOCK/(BAUD_RATE*N_TICKS) must be at least 1");
  end
  if ((NB_DATA % NB_BYTE) != 0) begin : g_bad_width
    $error("tx_baudrate: NB_DATA must be a multiple of NB_BYTE");
  end

  uart_state_t        state_q, state_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]  byte_idx_q, byte_idx_d;
  logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
  logic               tx_d, ready_d, busy_d, done_d;
  logic               tick_en, tick, bit_end;

  // The tick generator starts the cycle after acceptance, so the first bit
  // period ends exactly N_TICKS*DIV clocks after the accepting edge.
  always_comb begin
    tick_en = (state_q != IDLE);
  end

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (tick_en),
    .o_tick   (tick)
  );

  always_comb begin
    bit_end = tick && (os_cnt_q == OS_LAST);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      os_cnt_q   <= '0;
      o_tx       <= 1'b1;
      o_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      os_cnt_q   <= os_cnt_d;
      o_tx       <= tx_d;
      o_ready    <= ready_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    os_cnt_d   = os_cnt_q;
    done_d     = 1'b0;

    if (tick) begin
      os_cnt_d = bit_end ? '0 : os_cnt_q + OS_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          shift_d    = i_data;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          os_cnt_d   = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q != BYTE_LAST) begin
            // Next byte is already at the bottom of the shift register.
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            bit_cnt_d  = '0;
            state_d    = START;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tx_baudrate.sv
// Bench for tx_baudrate with DIV=1 (16 clocks per bit). Expected line levels
// come from the 8N1 frame rule: bit n of a word is frame n/10, position n%10
// (0 = start, 1..8 = data LSB first, 9 = stop).
module tb_tx_baudrate;

  localparam int unsigned NB_DATA = 16;
  localparam int unsigned BIT_CLK = 16;
  localparam int unsigned W       = (NB_DATA / 8) * 10 * BIT_CLK;

  logic               clk;
  logic               rst_n;
  logic [NB_DATA-1:0] data;
  logic               valid;
  logic               ready, tx, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  tx_baudrate #(
    .NB_DATA   (16),
    .NB_BYTE   (8),
    .F_CLOCK   (5000000),
    .BAUD_RATE (312500),
    .N_TICKS   (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (ready),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [NB_DATA-1:0] d, input int n);
    int f;
    int p;
    f = n / 10;
    p = n % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return d[f*8 + p - 1];
  endfunction

  // Called at #1 after the accepting edge; returns at #1 after edge k+W.
  task automatic check_word(input logic [NB_DATA-1:0] d, input bit offer);
    for (int c = 1; c <= W; c++) begin
      @(posedge clk); #1;
      if (offer) begin
        if (c == 40) begin valid = 1'b1; data = 16'hBEEF; end
        if (c == W - 5) valid = 1'b0;
      end
      if (c < W) begin
        if ((c % BIT_CLK == 0) || (c % BIT_CLK == BIT_CLK - 1))
          check_eq($sformatf("tx_bit%0d_c%0d", c / BIT_CLK, c), tx,
                   exp_bit(d, c / BIT_CLK));
        if (c % BIT_CLK == BIT_CLK - 1) begin
          check_eq("busy_mid", busy, 1);
          check_eq("ready_mid", ready, 0);
          check_eq("done_mid", done, 0);
        end
      end else begin
        check_eq("done_pulse", done, 1);
        check_eq("ready_end", ready, 1);
        check_eq("busy_end", busy, 0);
        check_eq("tx_end", tx, 1);
      end
    end
  endtask

  task automatic accept_checks();
    check_eq("tx_accept", tx, 0);
    check_eq("busy_accept", busy, 1);
    check_eq("ready_accept", ready, 0);
    check_eq("done_accept", done, 0);
  endtask

  task automatic send_word(input logic [NB_DATA-1:0] d, input bit offer);
    check_eq("ready_before", ready, 1);
    valid = 1'b1;
    data  = d;
    @(posedge clk); #1;
    valid = 1'b0;
    accept_checks();
    check_word(d, offer);
    @(posedge clk); #1;
    check_eq("done_drop", done, 0);
    check_eq("tx_idle", tx, 1);
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB_DATA-1:0] rnd;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;

    // Reset idle
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst_tx", tx, 1);
      check_eq("rst_ready", ready, 0);
      check_eq("rst_busy", busy, 0);
    end
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", ready, 1);
    check_eq("tx_after_rst", tx, 1);

    // Single word
    send_word(16'hA55A, 1'b0);
    // Word used as the loopback pattern
    send_word(16'h1234, 1'b0);

    // Back-to-back with valid held high
    valid = 1'b1;
    data  = 16'hFFFF;
    @(posedge clk); #1;
    data = 16'h0000;
    accept_checks();
    check_word(16'hFFFF, 1'b0);
    @(posedge clk); #1;
    check_eq("b2b_tx_start", tx, 0);
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_ready", ready, 0);
    check_eq("b2b_done_drop", done, 0);
    valid = 1'b0;
    check_word(16'h0000, 1'b0);
    @(posedge clk); #1;
    check_eq("b2b_idle_tx", tx, 1);

    // Busy ignore: BEEF offered mid-word must never be accepted
    send_word(16'h00FF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("ignore_busy", busy, 0);
      check_eq("ignore_tx", tx, 1);
    end

    // Reset mid-frame
    valid = 1'b1;
    data  = 16'h0000;
    @(posedge clk); #1;
    valid = 1'b0;
    accept_checks();
    repeat (100) @(posedge clk);
    #1;
    check_eq("mid_tx_before", tx, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", tx, 1);
    check_eq("mid_rst_ready", ready, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_ready_after", ready, 1);
    send_word(16'h00C3, 1'b0);

    // Random words with random idle gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      rnd = NB_DATA'($urandom & 32'hFFFF);
      send_word(rnd, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
